// File: rtl/encoder_tachometer.sv
// Encoder tachometer: counts qualified edges of one encoder channel over a fixed window of
// clock cycles and publishes the count once per window as a 32-bit rate word.
//
// Ports
//   clock         system clock
//   reset_n       asynchronous reset, active-high (clears all state)
//   encoder_data  raw asynchronous encoder channel
//   data_out      edge count of the last completed window (registered, held between updates)
//
// Rate in Hz = data_out * f_clk / WINDOW_CYCLES (halve it when BOTH_EDGES = 1).
module encoder_tachometer #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned FILTER_LEN    = 2,
  parameter bit          BOTH_EDGES    = 1'b0,
  parameter logic [31:0] SAT_MAX       = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        encoder_data,
  output logic [31:0] data_out
);

  localparam int unsigned WinW  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN);

  // Saturating increment; also clamps anything already above SAT_MAX.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    logic [32:0] sum;
    sum = {1'b0, v} + {32'd0, inc};
    if (sum > {1'b0, SAT_MAX}) begin
      return SAT_MAX;
    end
    return sum[31:0];
  endfunction

  // Two-flop synchronizer
  logic sync1_q, sync_q;

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= encoder_data;
      sync_q  <= sync1_q;
    end
  end

  // Glitch filter: a level change is accepted only after FILTER_LEN consecutive
  // synced samples disagree with the current filtered level.
  logic             filt_lvl_q, filt_lvl_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic [FiltW-1:0] filt_cnt_inc;

  assign filt_cnt_inc = filt_cnt_q + FiltW'(1);

  always_comb begin
    filt_lvl_d = filt_lvl_q;
    filt_cnt_d = '0;
    if (sync_q != filt_lvl_q) begin
      if (filt_cnt_inc == FiltMax) begin
        filt_lvl_d = sync_q;
      end else begin
        filt_cnt_d = filt_cnt_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      filt_lvl_q <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_lvl_q <= filt_lvl_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Strobe fires in the cycle whose closing edge updates filt_lvl, so the edge is
  // counted on the same clock that the filtered level changes.
  logic rise, fall, strobe;

  assign rise   = filt_lvl_d & ~filt_lvl_q;
  assign fall   = ~filt_lvl_d & filt_lvl_q;
  assign strobe = rise | (BOTH_EDGES & fall);

  // Window counter, edge counter and published result
  logic [WinW-1:0] win_cnt_q, win_cnt_d;
  logic [31:0]     edge_cnt_q, edge_cnt_d;
  logic [31:0]     data_out_q, data_out_d;
  logic            win_last;

  assign win_last = (win_cnt_q == WinLast);

  always_comb begin
    win_cnt_d  = win_cnt_q + WinW'(1);
    edge_cnt_d = sat_inc(edge_cnt_q, strobe);
    data_out_d = data_out_q;
    if (win_last) begin
      win_cnt_d  = '0;
      // A strobe on the closing cycle belongs to the closing window.
      data_out_d = sat_inc(edge_cnt_q, strobe);
      edge_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      data_out_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_encoder_tachometer.sv
// Directed bench for encoder_tachometer. Three instances share clock, reset and input:
// defaults, BOTH_EDGES=1, and SAT_MAX=100. Cycle index cyc counts negedges since reset
// release; the window ending at posedge k*1000 is visible at cyc == k*1000.
module tb_encoder_tachometer;

  logic        clock;
  logic        reset_n;
  logic        encoder_data;
  logic [31:0] dout;
  logic [31:0] dout_both;
  logic [31:0] dout_sat;

  int total;
  int bad;
  int cyc;

  typedef enum logic [2:0] {ModeLow, ModeHigh, ModeToggle, ModeGlitch1, ModePulse2} mode_e;
  mode_e mode;

  encoder_tachometer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .encoder_data (encoder_data),
    .data_out     (dout)
  );

  encoder_tachometer #(
    .BOTH_EDGES (1'b1)
  ) dut_both (
    .clock        (clock),
    .reset_n      (reset_n),
    .encoder_data (encoder_data),
    .data_out     (dout_both)
  );

  encoder_tachometer #(
    .SAT_MAX (32'd100)
  ) dut_sat (
    .clock        (clock),
    .reset_n      (reset_n),
    .encoder_data (encoder_data),
    .data_out     (dout_sat)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pin value driven at negedge number c after release.
  function automatic logic pin_value(input mode_e m, input int c);
    case (m)
      ModeHigh:    return 1'b1;
      ModeToggle:  return ((c / 20) % 2) == 1;
      ModeGlitch1: return (c % 50) == 25;
      ModePulse2:  return (c % 4) >= 2;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic run_to(input int target);
    while (cyc < target) begin
      @(negedge clock);
      cyc++;
      encoder_data = pin_value(mode, cyc);
    end
  endtask

  // Assert reset, hold it for n negedges checking every output, release on the last one.
  task automatic apply_reset(input int n, input bit toggle);
    reset_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (toggle) encoder_data = ~encoder_data;
      check_eq("rst_dout", dout, 32'd0);
      check_eq("rst_dout_both", dout_both, 32'd0);
      check_eq("rst_dout_sat", dout_sat, 32'd0);
    end
    reset_n      = 1'b0;
    encoder_data = 1'b0;
    cyc          = 0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc          = 0;
    reset_n      = 1'b1;
    encoder_data = 1'b0;
    mode         = ModeLow;

    // 1: reset held with a toggling input
    apply_reset(10, 1'b1);

    // 2/5: toggle every 20 clocks. Filtered rises land at posedge 24+40k, falls at 44+40k.
    mode = ModeToggle;
    run_to(999);
    check_eq("t2_before_first_update", dout, 32'd0);
    run_to(1000);
    check_eq("t2_w1", dout, 32'd25);
    check_eq("t5_w1_both", dout_both, 32'd49);
    run_to(1500);
    check_eq("t2_hold_mid", dout, 32'd25);
    for (int w = 2; w <= 4; w++) begin
      run_to(w * 1000);
      check_eq("t2_steady", dout, 32'd25);
      check_eq("t5_steady_both", dout_both, 32'd50);
      check_eq("t2_steady_sat", dout_sat, 32'd25);
    end

    // 3: constant low for 3 windows, then constant high for 3 windows
    apply_reset(3, 1'b0);
    mode = ModeLow;
    for (int w = 1; w <= 3; w++) begin
      run_to(w * 1000);
      check_eq("t3_low", dout, 32'd0);
      check_eq("t3_low_both", dout_both, 32'd0);
    end
    mode = ModeHigh;
    run_to(4000);
    check_eq("t3_single_rise", dout, 32'd1);
    check_eq("t3_single_rise_both", dout_both, 32'd1);
    for (int w = 5; w <= 6; w++) begin
      run_to(w * 1000);
      check_eq("t3_high", dout, 32'd0);
      check_eq("t3_high_both", dout_both, 32'd0);
    end

    // 4a: 1-cycle pulses are shorter than the filter and never accepted
    apply_reset(3, 1'b0);
    mode = ModeGlitch1;
    for (int w = 1; w <= 2; w++) begin
      run_to(w * 1000);
      check_eq("t4_glitch", dout, 32'd0);
      check_eq("t4_glitch_both", dout_both, 32'd0);
    end

    // 4b: 2-cycle pulses every 4 clocks; filtered rises at posedge 6+4k, falls at 8+4k
    apply_reset(3, 1'b0);
    mode = ModePulse2;
    run_to(1000);
    check_eq("t4_pulse_w1", dout, 32'd249);
    check_eq("t4_pulse_w1_sat", dout_sat, 32'd100);
    for (int w = 2; w <= 3; w++) begin
      run_to(w * 1000);
      check_eq("t4_pulse", dout, 32'd250);
      check_eq("t4_pulse_both", dout_both, 32'd500);
      check_eq("t4_pulse_sat", dout_sat, 32'd100);
    end

    // 6: reset at window cycle 500 clears data_out at once
    apply_reset(3, 1'b0);
    mode = ModeToggle;
    run_to(2500);
    check_eq("t6_before_reset", dout, 32'd25);
    #3 reset_n = 1'b1;
    #1;
    check_eq("t6_async_clear", dout, 32'd0);
    check_eq("t6_async_clear_both", dout_both, 32'd0);
    apply_reset(3, 1'b0);
    run_to(999);
    check_eq("t6_hold_zero", dout, 32'd0);
    run_to(1000);
    check_eq("t6_post_reset", dout, 32'd25);
    check_eq("t6_post_reset_both", dout_both, 32'd49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
